// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator: FSM state encoding and default parameters.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEAD = 3'd1,
      LOW  = 3'd2,
      HIGH = 3'd3,
      DONE = 3'd4
   } spi_state_t;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CLK_DIV    = 2;
   localparam int DEF_NUM_CS     = 4;

endpackage

// File: rtl/spi_sck_div.sv
// Phase timer: tick marks the last clk cycle of a CLK_DIV-long SCK phase.
module spi_sck_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   logic [7:0] cnt;

   // restart is asserted on every state change, so each phase counts from zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 8'd0;
      end else if (restart) begin
         cnt <= 8'd0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   assign tick = (cnt == 8'(CLK_DIV - 1));

endmodule

// File: rtl/spi_initiator.sv
// SPI mode-3 initiator: one frame per request, MSB first, all pins driven from flops.
// Handshake: a frame is accepted on a clk edge where tx_valid && tx_ready; tx_ready is high only in IDLE.
module spi_initiator
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int NUM_CS     = DEF_NUM_CS,
   parameter int CS_W       = $clog2(NUM_CS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic [CS_W-1:0]       tx_cs,
   output logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  busy,
   output logic                  sck,
   output logic [NUM_CS-1:0]     csn,
   output logic                  mosi,
   input  logic                  miso,
   output logic [2:0]            state
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   spi_state_t            state_q, state_d;
   logic                  tick;
   logic                  accept;
   logic                  last_bit;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [CS_W-1:0]       cs_q;
   logic [CS_W-1:0]       cs_sel;
   logic [NUM_CS-1:0]     csn_d;

   assign accept   = tx_valid && tx_ready;
   assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
   assign state    = state_q;

   spi_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk     (clk),
      .rst     (rst),
      .restart (state_d != state_q),
      .tick    (tick)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = LEAD;
         LEAD:    if (tick) state_d = LOW;
         LOW:     if (tick) state_d = HIGH;
         HIGH:    if (tick) state_d = last_bit ? DONE : LOW;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // at the acceptance edge the latched index is not yet valid, so use the live input
   always_comb begin
      cs_sel = accept ? tx_cs : cs_q;
      csn_d  = '1;
      if (state_d == LEAD || state_d == LOW || state_d == HIGH) begin
         csn_d[cs_sel] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         tx_ready <= 1'b0;
         busy     <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         sck      <= 1'b1;
         csn      <= '1;
         mosi     <= 1'b0;
         tx_shift <= '0;
         rx_shift <= '0;
         bit_cnt  <= '0;
         cs_q     <= '0;
      end else begin
         state_q  <= state_d;
         tx_ready <= (state_d == IDLE);
         busy     <= (state_d != IDLE);
         rx_valid <= (state_d == DONE);
         sck      <= (state_d != LOW);
         csn      <= csn_d;
         if (accept) begin
            tx_shift <= tx_data;
            cs_q     <= tx_cs;
            bit_cnt  <= '0;
         end
         // mosi only moves when SCK falls; it holds its value everywhere else
         if (state_q != LOW && state_d == LOW) begin
            mosi <= tx_shift[DATA_WIDTH-1];
         end
         if (state_q == LOW && state_d == HIGH) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
         end
         if (state_q == HIGH && state_d == LOW) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
         end
         if (state_d == DONE) begin
            rx_data <= rx_shift;
         end
      end
   end

endmodule

// File: tb/tb_spi_initiator.sv
// Bench for spi_initiator: table of single frames plus hand sequences for back-to-back, abort and fast-clock cases.
module tb_spi_initiator;

   logic       clk;
   logic       rst;

   logic       tx_valid0, tx_ready0, rx_valid0, busy0, sck0, mosi0, miso0;
   logic [7:0] tx_data0, rx_data0;
   logic [1:0] tx_cs0;
   logic [3:0] csn0;
   logic [2:0] state0;

   logic       tx_valid1, tx_ready1, rx_valid1, busy1, sck1, mosi1;
   logic [7:0] tx_data1, rx_data1;
   logic [1:0] tx_cs1;
   logic [3:0] csn1;
   logic [2:0] state1;

   spi_initiator dut0 (
      .clk(clk), .rst(rst), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_data(tx_data0),
      .tx_cs(tx_cs0), .rx_valid(rx_valid0), .rx_data(rx_data0), .busy(busy0), .sck(sck0),
      .csn(csn0), .mosi(mosi0), .miso(miso0), .state(state0)
   );

   spi_initiator #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
      .tx_cs(tx_cs1), .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1), .sck(sck1),
      .csn(csn1), .mosi(mosi1), .miso(mosi1), .state(state1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // peripheral model: loopback or a fixed reply word indexed by SCK rising edges seen
   logic       loop_mode;
   logic [7:0] pat;
   int         rise_cnt = 0;

   always_comb begin
      if (loop_mode) miso0 = mosi0;
      else if (rise_cnt < 8) miso0 = pat[7 - rise_cnt];
      else miso0 = 1'b0;
   end

   // negedge monitor
   int         cyc = 0, low_cnt = 0, acc_cyc = 0, last_lat = 0, rx_cnt = 0;
   int         rb_bad = 0, gap = 0, min_gap = 99;
   logic       in_gap = 1'b0;
   logic [7:0] last_rx = 8'h00, mosi_word = 8'h00;
   logic [3:0] csn_seen = 4'hF, csn0_prev = 4'hF;
   logic       sck0_prev = 1'b1;
   int         low1_cnt = 0, acc1_cyc = 0, lat1 = 0, rx1_cnt = 0;
   logic [7:0] last_rx1 = 8'h00;
   logic [3:0] csn1_prev = 4'hF;

   always @(negedge clk) begin
      cyc++;
      if (csn0 != 4'hF && csn0_prev == 4'hF) begin
         rise_cnt  = 0;
         low_cnt   = 0;
         mosi_word = 8'h00;
      end
      if (csn0 != 4'hF) begin
         csn_seen = csn0;
         if (!sck0) low_cnt++;
      end
      if (sck0 && !sck0_prev) begin
         rise_cnt++;
         mosi_word = {mosi_word[6:0], mosi0};
      end
      if (tx_valid0 && tx_ready0) acc_cyc = cyc;
      if (rx_valid0) begin
         last_lat = cyc - acc_cyc;
         last_rx  = rx_data0;
         rx_cnt++;
      end
      if (tx_ready0 && busy0) rb_bad++;
      if (rx_valid0) begin
         gap    = 0;
         in_gap = 1'b1;
      end else if (in_gap && csn0 == 4'hF) begin
         gap++;
      end else if (in_gap) begin
         in_gap = 1'b0;
         if (gap < min_gap) min_gap = gap;
      end
      if (csn1 != 4'hF && csn1_prev == 4'hF) low1_cnt = 0;
      if (csn1 != 4'hF && !sck1) low1_cnt++;
      if (tx_valid1 && tx_ready1) acc1_cyc = cyc;
      if (rx_valid1) begin
         lat1     = cyc - acc1_cyc;
         last_rx1 = rx_data1;
         rx1_cnt++;
      end
      csn0_prev = csn0;
      sck0_prev = sck0;
      csn1_prev = csn1;
   end

   // scoreboard
   logic [7:0] exp_q[$];
   int         n_cmp = 0;
   int         n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // driver tasks (called at posedge+#1)
   task automatic send0(input logic [7:0] d, input logic [1:0] cs);
      int t = 0;
      while (!tx_ready0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      tx_data0  = d;
      tx_cs0    = cs;
      tx_valid0 = 1'b1;
      @(posedge clk); #1;
      tx_valid0 = 1'b0;
   endtask

   task automatic wait_rx0(input int n0);
      int t = 0;
      while (rx_cnt <= n0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      chk("rx_timeout", 32'(rx_cnt > n0), 32'd1);
      #1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic [1:0] cs;
      logic       loop;
      logic [7:0] pat;
      logic [7:0] exp_rx;
      logic [3:0] exp_csn;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int n0;
      int t;
      vecs[0] = '{8'hA5, 2'd0, 1'b1, 8'h00, 8'hA5, 4'b1110};
      vecs[1] = '{8'hFF, 2'd2, 1'b0, 8'h3C, 8'h3C, 4'b1011};
      vecs[2] = '{8'h96, 2'd3, 1'b1, 8'h00, 8'h96, 4'b0111};
      vecs[3] = '{8'h00, 2'd1, 1'b0, 8'hC5, 8'hC5, 4'b1101};

      rst = 1'b1;
      tx_valid0 = 1'b0; tx_data0 = 8'h00; tx_cs0 = 2'd0;
      tx_valid1 = 1'b0; tx_data1 = 8'h00; tx_cs1 = 2'd0;
      loop_mode = 1'b1; pat = 8'h00;

      // reset state
      #7;
      chk("rst_sck", 32'(sck0), 32'd1);
      chk("rst_csn", 32'(csn0), 32'hF);
      chk("rst_mosi", 32'(mosi0), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid0), 32'd0);
      chk("rst_rx_data", 32'(rx_data0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready0), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", 32'(tx_ready0), 32'd1);

      // single frames from the table
      for (int i = 0; i < 4; i++) begin
         loop_mode = vecs[i].loop;
         pat       = vecs[i].pat;
         n0        = rx_cnt;
         exp_q.push_back(vecs[i].exp_rx);
         send0(vecs[i].data, vecs[i].cs);
         wait_rx0(n0);
         chk("rx_data", 32'(last_rx), 32'(exp_q.pop_front()));
         chk("latency", 32'(last_lat), 32'd35);
         chk("csn_frame", 32'(csn_seen), 32'(vecs[i].exp_csn));
         chk("mosi_word", 32'(mosi_word), 32'(vecs[i].data));
         chk("sck_rises", 32'(rise_cnt), 32'd8);
         chk("sck_low_cycles", 32'(low_cnt), 32'd16);
      end

      // tx_data changes one cycle after acceptance
      loop_mode = 1'b1;
      n0 = rx_cnt;
      exp_q.push_back(8'h0F);
      send0(8'h0F, 2'd3);
      tx_data0 = 8'hF0;
      wait_rx0(n0);
      chk("late_change_rx", 32'(last_rx), 32'(exp_q.pop_front()));
      chk("late_change_mosi", 32'(mosi_word), 32'h0F);

      // tx_valid held high across three frames
      n0 = rx_cnt;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h55);
      fork
         begin
            tx_cs0 = 2'd0; tx_data0 = 8'h01; tx_valid0 = 1'b1;
            for (int k = 0; k < 3; k++) begin
               int tw = 0;
               while (!tx_ready0 && tw < 200) begin
                  @(posedge clk); #1;
                  tw++;
               end
               @(posedge clk); #1;
               if (k == 0) tx_data0 = 8'h80;
               else if (k == 1) tx_data0 = 8'h55;
               else tx_valid0 = 1'b0;
            end
         end
         begin
            for (int k = 0; k < 3; k++) begin
               wait_rx0(n0 + k);
               chk("held_rx", 32'(last_rx), 32'(exp_q.pop_front()));
            end
         end
      join
      repeat (5) @(posedge clk);
      #1;
      chk("held_rx_count", 32'(rx_cnt - n0), 32'd3);
      chk("idle_gap_csn_high", 32'(min_gap >= 1), 32'd1);
      chk("ready_while_busy", 32'(rb_bad), 32'd0);

      // reset during bit 4 aborts the frame
      send0(8'h77, 2'd1);
      t = 0;
      while (!(rise_cnt == 4 && sck0 == 1'b0) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("abort_reached_bit4", 32'(rise_cnt == 4 && sck0 == 1'b0), 32'd1);
      n0 = rx_cnt;
      #2 rst = 1'b1;
      #1;
      chk("abort_csn", 32'(csn0), 32'hF);
      chk("abort_sck", 32'(sck0), 32'd1);
      chk("abort_busy", 32'(busy0), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_ready", 32'(tx_ready0), 32'd1);
      chk("abort_no_rx", 32'(rx_cnt), 32'(n0));
      exp_q.push_back(8'hC3);
      send0(8'hC3, 2'd2);
      wait_rx0(n0);
      chk("after_abort_rx", 32'(last_rx), 32'(exp_q.pop_front()));
      chk("after_abort_latency", 32'(last_lat), 32'd35);

      // CLK_DIV=1 loopback
      n0 = rx1_cnt;
      tx_data1 = 8'h5A; tx_cs1 = 2'd1; tx_valid1 = 1'b1;
      @(posedge clk); #1;
      tx_valid1 = 1'b0;
      t = 0;
      while (rx1_cnt == n0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("div1_rx_seen", 32'(rx1_cnt - n0), 32'd1);
      chk("div1_rx_data", 32'(last_rx1), 32'h5A);
      chk("div1_latency", 32'(lat1), 32'd18);
      chk("div1_sck_low_cycles", 32'(low1_cnt), 32'd8);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_initiator.md
SPI_INITIATOR -- requirements
Module: spi_initiator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame length in bits.
REQ-002 SHALL have parameter CLK_DIV, default 2, SCK half-period in clk cycles; legal range 1..255.
REQ-003 SHALL have parameter NUM_CS, default 4, number of chip selects; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port tx_valid  input  1  request to start one frame.
REQ-007 SHALL have port tx_ready  output  1  high when a request can be accepted.
REQ-008 SHALL have port tx_data  input  DATA_WIDTH  word to transmit, MSB first.
REQ-009 SHALL have port tx_cs  input  clog2(NUM_CS)  index of the chip select to assert.
REQ-010 SHALL have port rx_valid  output  1  one-cycle pulse, received word available.
REQ-011 SHALL have port rx_data  output  DATA_WIDTH  received word.
REQ-012 SHALL have port busy  output  1  high from acceptance until return to IDLE.
REQ-013 SHALL have port sck  output  1  serial clock, idle high.
REQ-014 SHALL have port csn  output  NUM_CS  active-low chip selects.
REQ-015 SHALL have port mosi  output  1  serial data out.
REQ-016 SHALL have port miso  input  1  serial data in.

Function
REQ-017 SHALL implement SPI mode 3: SCK idles high; mosi changes on SCK falling edge; miso sampled on SCK rising edge; MSB first.
REQ-018 SHALL use states IDLE, LEAD, LOW, HIGH, DONE, all registered, with sck, csn and mosi driven from flops (no glitches).
REQ-019 SHALL accept a frame on a clk edge where tx_valid and tx_ready are both high; tx_ready is high only in IDLE.
REQ-020 SHALL latch tx_data and tx_cs at acceptance; later changes to either have no effect on the current frame.
REQ-021 SHALL enter LEAD at acceptance, with csn[tx_cs] low, all other csn bits high and sck high, for CLK_DIV cycles.
REQ-022 SHALL, per bit, spend CLK_DIV cycles in LOW (sck=0, mosi=current bit) and then CLK_DIV cycles in HIGH (sck=1).
REQ-023 SHALL shift miso into the receive register on the clk edge that moves from LOW to HIGH.
REQ-024 SHALL, after the HIGH phase of bit DATA_WIDTH-1, enter DONE for exactly 1 cycle: all csn high, rx_valid=1, rx_data=received word; then return to IDLE.
REQ-025 SHALL give latency from acceptance edge to the rx_valid-high edge of CLK_DIV*(2*DATA_WIDTH+1)+1 cycles (35 at defaults).
REQ-026 SHALL hold rx_data stable from DONE until the next DONE; rx_valid has no backpressure.
REQ-027 SHALL keep at least one IDLE cycle with all csn high between back-to-back frames.
REQ-028 SHALL ignore tx_valid while busy; no queueing and no error flag.
REQ-029 SHALL keep mosi at its last driven value in HIGH, DONE and IDLE phases after the first frame.

Reset
REQ-030 SHALL on rst, immediately and asynchronously, set state=IDLE, sck=1, csn=all ones, mosi=0, rx_valid=0, rx_data=0, busy=0, tx_ready=0 while rst high.
REQ-031 SHALL abort any frame in progress on rst with no rx_valid pulse; tx_ready=1 on the first clk edge after rst deasserts.

Structure
REQ-032 SHALL take the state enumeration and default parameter values from a shared package spi_pkg.
REQ-033 SHALL use one sub-module spi_sck_div generating the CLK_DIV phase-end tick, restarted at every state change.

Verification
REQ-034 SHALL cover loopback (miso tied to mosi), defaults, tx_data=8'hA5, tx_cs=0 -> csn=4'b1110 during the frame, rx_data=8'hA5, rx_valid 35 cycles after acceptance.
REQ-035 SHALL cover miso driven by a model returning 8'h3C with tx_data=8'hFF, tx_cs=2 -> csn=4'b1011, mosi all ones, rx_data=8'h3C, exactly 8 sck rising edges.
REQ-036 SHALL cover tx_valid held high for 3 frames (8'h01, 8'h80, 8'h55) -> three rx_valid pulses, at least one all-high csn cycle between frames, tx_ready low while busy.
REQ-037 SHALL cover rst asserted in bit 4 of a frame -> csn=4'hF and sck=1 without a clk edge, no rx_valid, next frame 8'hC3 completes correctly.
REQ-038 SHALL cover CLK_DIV=1 loopback of 8'h5A -> SCK half-period 1 clk, rx_data=8'h5A, latency 18 cycles.
REQ-039 SHALL cover tx_data changed from 8'h0F to 8'hF0 one cycle after acceptance -> mosi carries 8'h0F.
